// File: rtl/cva6_clic_pkg.sv
// Shared types for the CLIC pending-interrupt arbiter: trigger encoding,
// per-source configuration word and default sizing.
package cva6_clic_pkg;

    localparam int unsigned CLIC_NUM_SRC    = 256;
    localparam int unsigned CLIC_PRIO_WIDTH = 8;

    typedef enum logic [1:0] {
        LEVEL_HIGH = 2'b00,
        EDGE_POS   = 2'b01,
        LEVEL_LOW  = 2'b10,
        EDGE_NEG   = 2'b11
    } clic_trig_e;

    typedef struct packed {
        logic                       ie;
        logic                       ip;
        clic_trig_e                 trig;
        logic [CLIC_PRIO_WIDTH-1:0] level;
        logic                       shv;
    } clic_cfg_t;

    // Bit 0 of the trigger code selects edge sensitivity.
    function automatic logic trig_is_edge(input clic_trig_e trig);
        return trig[0];
    endfunction

endpackage

// File: rtl/cva6_clic_max_tree.sv
// Combinational maximum-level selector over all interrupt sources.
// Pairwise reduction in log2(NumSrc) stages; on equal levels the higher id wins.
module cva6_clic_max_tree #(
    parameter int NumSrc    = 256,
    parameter int PrioWidth = 8,
    parameter int IdWidth   = $clog2(NumSrc)
) (
    input  logic [NumSrc-1:0]                elig_i,
    input  logic [NumSrc-1:0][PrioWidth-1:0] level_i,
    output logic                             any_o,
    output logic [PrioWidth-1:0]             level_o,
    output logic [IdWidth-1:0]               id_o
);

    localparam int Depth  = $clog2(NumSrc);
    localparam int Leaves = 1 << Depth;

    logic                 any_t [Leaves];
    logic [PrioWidth-1:0] lvl_t [Leaves];
    logic [IdWidth-1:0]   id_t  [Leaves];

    // Reduce candidate pairs stage by stage; node j of a stage overwrites slot j
    // after its children (2j, 2j+1) have been consumed.
    always_comb begin
        logic take_hi;
        take_hi = 1'b0;
        for (int i = 0; i < Leaves; i++) begin
            if (i < NumSrc) begin
                any_t[i] = elig_i[i];
                lvl_t[i] = level_i[i];
                id_t[i]  = IdWidth'(i);
            end else begin
                any_t[i] = 1'b0;
                lvl_t[i] = {PrioWidth{1'b0}};
                id_t[i]  = {IdWidth{1'b0}};
            end
        end
        for (int s = 0; s < Depth; s++) begin
            for (int j = 0; j < (Leaves >> (s + 1)); j++) begin
                take_hi = any_t[2*j+1] &
                          (~any_t[2*j] | (lvl_t[2*j+1] >= lvl_t[2*j]));
                if (take_hi) begin
                    any_t[j] = 1'b1;
                    lvl_t[j] = lvl_t[2*j+1];
                    id_t[j]  = id_t[2*j+1];
                end else begin
                    any_t[j] = any_t[2*j];
                    lvl_t[j] = lvl_t[2*j];
                    id_t[j]  = id_t[2*j];
                end
            end
        end
        any_o   = any_t[0];
        level_o = lvl_t[0];
        id_o    = id_t[0];
    end

endmodule

// File: rtl/cva6_clic_irq_arbiter.sv
// CLIC pending-interrupt arbiter: per-source enable/pending/trigger/level
// state, highest-level selection above threshold and a registered
// valid/ready offer to the core.
// Optional build macro CVA6_CLIC_IRQ_SYNC_EN: adds a 2-flop synchroniser on
// irq_src_i (two extra cycles of latency).
module cva6_clic_irq_arbiter
    import cva6_clic_pkg::*;
#(
    parameter int NumSrc    = CLIC_NUM_SRC,
    parameter int PrioWidth = CLIC_PRIO_WIDTH,
    parameter int IdWidth   = $clog2(NumSrc)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumSrc-1:0]    irq_src_i,
    input  logic                 cfg_we_i,
    input  logic [IdWidth-1:0]   cfg_idx_i,
    input  clic_cfg_t            cfg_i,
    input  logic [PrioWidth-1:0] thresh_i,
    output logic                 irq_valid_o,
    output logic [IdWidth-1:0]   irq_id_o,
    output logic [PrioWidth-1:0] irq_level_o,
    output logic                 irq_shv_o,
    input  logic                 irq_ready_i
);

    logic [NumSrc-1:0] line_s;

`ifdef CVA6_CLIC_IRQ_SYNC_EN
    logic [NumSrc-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    // Next state of the two synchroniser stages.
    always_comb begin
        sync1_d = irq_src_i;
        sync2_d = sync1_q;
    end

    // Synchroniser flops, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= {NumSrc{1'b0}};
            sync2_q <= {NumSrc{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign line_s = sync2_q;
`else
    assign line_s = irq_src_i;
`endif

    // Per-source state.
    logic [NumSrc-1:0]                ie_q, ie_d, ip_q, ip_d, shv_q, shv_d, prev_q, prev_d;
    logic [NumSrc-1:0][PrioWidth-1:0] level_q, level_d;
    clic_trig_e                       trig_q [NumSrc];
    clic_trig_e                       trig_d [NumSrc];

    // Output offer register.
    logic                 out_valid_q, out_valid_d;
    logic [IdWidth-1:0]   out_id_q, out_id_d;
    logic [PrioWidth-1:0] out_level_q, out_level_d;
    logic                 out_shv_q, out_shv_d;

    logic [NumSrc-1:0]    elig_s;
    logic [NumSrc-1:0]    ack_clr_s;
    logic                 ack_s;
    logic                 cfg_hit_s;
    logic                 held_ok_s;
    logic                 win_any_s;
    logic [PrioWidth-1:0] win_level_s;
    logic [IdWidth-1:0]   win_id_s;

    assign ack_s     = out_valid_q & irq_ready_i;
    assign cfg_hit_s = cfg_we_i & ({1'b0, cfg_idx_i} < (IdWidth + 1)'(NumSrc));
    assign held_ok_s = elig_s[out_id_q];

    // One-hot of the source whose offer the core accepts this cycle.
    always_comb begin
        ack_clr_s = {NumSrc{1'b0}};
        if (ack_s) begin
            ack_clr_s[out_id_q] = 1'b1;
        end else begin
            ack_clr_s = {NumSrc{1'b0}};
        end
    end

    // Pending/trigger update; a config write overrides everything for its source.
    always_comb begin
        ie_d    = ie_q;
        ip_d    = ip_q;
        shv_d   = shv_q;
        level_d = level_q;
        trig_d  = trig_q;
        prev_d  = line_s;
        for (int i = 0; i < NumSrc; i++) begin
            case (trig_q[i])
                LEVEL_HIGH: ip_d[i] = line_s[i];
                LEVEL_LOW:  ip_d[i] = ~line_s[i];
                EDGE_POS:   ip_d[i] = (line_s[i] & ~prev_q[i]) | (ip_q[i] & ~ack_clr_s[i]);
                EDGE_NEG:   ip_d[i] = (~line_s[i] & prev_q[i]) | (ip_q[i] & ~ack_clr_s[i]);
                default:    ip_d[i] = ip_q[i];
            endcase
        end
        if (cfg_hit_s) begin
            ie_d[cfg_idx_i]    = cfg_i.ie;
            trig_d[cfg_idx_i]  = cfg_i.trig;
            level_d[cfg_idx_i] = cfg_i.level;
            shv_d[cfg_idx_i]   = cfg_i.shv;
            // Edge history keeps tracking the line, so a trigger change never sees a stale edge.
            if (trig_is_edge(cfg_i.trig)) begin
                ip_d[cfg_idx_i] = cfg_i.ip;
            end else if (cfg_i.trig == LEVEL_LOW) begin
                ip_d[cfg_idx_i] = ~line_s[cfg_idx_i];
            end else begin
                ip_d[cfg_idx_i] = line_s[cfg_idx_i];
            end
        end else begin
            ie_d = ie_d;
        end
    end

    // Eligibility: enabled, pending and strictly above threshold.
    always_comb begin
        elig_s = {NumSrc{1'b0}};
        for (int i = 0; i < NumSrc; i++) begin
            elig_s[i] = ie_q[i] & ip_q[i] & (level_q[i] > thresh_i);
        end
    end

    cva6_clic_max_tree #(
        .NumSrc    (NumSrc),
        .PrioWidth (PrioWidth),
        .IdWidth   (IdWidth)
    ) u_max_tree (
        .elig_i  (elig_s),
        .level_i (level_q),
        .any_o   (win_any_s),
        .level_o (win_level_s),
        .id_o    (win_id_s)
    );

    // Offer register: bubble after ack, otherwise reload when idle, when the held
    // source lost eligibility, or when a strictly higher level appears.
    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_level_d = out_level_q;
        out_shv_d   = out_shv_q;
        if (ack_s) begin
            out_valid_d = 1'b0;
        end else if (!out_valid_q || !held_ok_s ||
                     (win_any_s && (win_level_s > out_level_q))) begin
            out_valid_d = win_any_s;
            if (win_any_s) begin
                out_id_d    = win_id_s;
                out_level_d = win_level_s;
                out_shv_d   = shv_q[win_id_s];
            end else begin
                out_id_d    = out_id_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ie_q        <= {NumSrc{1'b0}};
            ip_q        <= {NumSrc{1'b0}};
            shv_q       <= {NumSrc{1'b0}};
            prev_q      <= {NumSrc{1'b0}};
            level_q     <= {NumSrc{{PrioWidth{1'b0}}}};
            for (int i = 0; i < NumSrc; i++) begin
                trig_q[i] <= LEVEL_HIGH;
            end
            out_valid_q <= 1'b0;
            out_id_q    <= {IdWidth{1'b0}};
            out_level_q <= {PrioWidth{1'b0}};
            out_shv_q   <= 1'b0;
        end else begin
            ie_q        <= ie_d;
            ip_q        <= ip_d;
            shv_q       <= shv_d;
            prev_q      <= prev_d;
            level_q     <= level_d;
            trig_q      <= trig_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_level_q <= out_level_d;
            out_shv_q   <= out_shv_d;
        end
    end

    assign irq_valid_o = out_valid_q;
    assign irq_id_o    = out_id_q;
    assign irq_level_o = out_level_q;
    assign irq_shv_o   = out_shv_q;

endmodule

// File: tb/tb_cva6_clic_irq_arbiter.sv
// Self-checking bench for cva6_clic_irq_arbiter: directed scenarios plus
// randomized traffic, compared every cycle against a behavioural model.
module tb_cva6_clic_irq_arbiter;
    import cva6_clic_pkg::*;

    localparam int N  = 256;
    localparam int PW = 8;
    localparam int IW = 8;
`ifdef CVA6_CLIC_IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [N-1:0]  irq_src;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    clic_cfg_t     cfg;
    logic [PW-1:0] thresh;
    logic          ready;
    logic          irq_valid;
    logic [IW-1:0] irq_id;
    logic [PW-1:0] irq_level;
    logic          irq_shv;

    always #5 clk = ~clk;

    cva6_clic_irq_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .irq_src_i   (irq_src),
        .cfg_we_i    (cfg_we),
        .cfg_idx_i   (cfg_idx),
        .cfg_i       (cfg),
        .thresh_i    (thresh),
        .irq_valid_o (irq_valid),
        .irq_id_o    (irq_id),
        .irq_level_o (irq_level),
        .irq_shv_o   (irq_shv),
        .irq_ready_i (ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Trigger kinds: 0 level-high, 1 rising edge, 2 level-low, 3 falling edge.
    bit       m_ie [N];
    bit       m_ip [N];
    bit       m_prev [N];
    bit       m_shv [N];
    int       m_trig [N];
    int       m_lvl [N];
    bit       m_v;
    int       m_id;
    int       m_ol;
    bit       m_os;
    bit [N-1:0] m_s1;
    bit [N-1:0] m_s2;

    function automatic bit m_elig(input int i);
        return m_ie[i] && m_ip[i] && (m_lvl[i] > int'(thresh));
    endfunction

    task automatic model_step();
        bit [N-1:0] line;
        int  best, best_lvl, ack_id;
        bit  best_shv, ack, held_ok, set_e;
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                m_ie[i] = 0; m_ip[i] = 0; m_prev[i] = 0; m_shv[i] = 0;
                m_trig[i] = 0; m_lvl[i] = 0;
            end
            m_v = 0; m_id = 0; m_ol = 0; m_os = 0; m_s1 = '0; m_s2 = '0;
            return;
        end
`ifdef CVA6_CLIC_IRQ_SYNC_EN
        line = m_s2; m_s2 = m_s1; m_s1 = irq_src;
`else
        line = irq_src;
`endif
        // winner: highest level, later (higher) id wins ties
        best = -1; best_lvl = 0; best_shv = 0;
        for (int i = 0; i < N; i++) begin
            if (m_elig(i) && (best < 0 || m_lvl[i] >= best_lvl)) begin
                best = i; best_lvl = m_lvl[i]; best_shv = m_shv[i];
            end
        end
        ack     = m_v && ready;
        ack_id  = m_id;
        held_ok = m_v && m_elig(m_id);
        // source pending state
        for (int i = 0; i < N; i++) begin
            if (m_trig[i] == 0) m_ip[i] = line[i];
            else if (m_trig[i] == 2) m_ip[i] = !line[i];
            else begin
                set_e = (m_trig[i] == 1) ? (line[i] && !m_prev[i]) : (!line[i] && m_prev[i]);
                if (ack && ack_id == i) m_ip[i] = 0;
                if (set_e) m_ip[i] = 1;
            end
            m_prev[i] = line[i];
        end
        if (cfg_we) begin
            m_ie[cfg_idx] = cfg.ie;
            m_trig[cfg_idx] = int'(cfg.trig);
            m_lvl[cfg_idx] = int'(cfg.level);
            m_shv[cfg_idx] = cfg.shv;
            if (m_trig[cfg_idx] == 1 || m_trig[cfg_idx] == 3) m_ip[cfg_idx] = cfg.ip;
            else if (m_trig[cfg_idx] == 2) m_ip[cfg_idx] = !line[cfg_idx];
            else m_ip[cfg_idx] = line[cfg_idx];
        end
        // offer
        if (ack) m_v = 0;
        else if (!m_v || !held_ok || (best >= 0 && best_lvl > m_ol)) begin
            m_v = (best >= 0);
            if (best >= 0) begin
                m_id = best; m_ol = best_lvl; m_os = best_shv;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_val("valid", 32'(irq_valid), 32'(m_v));
        if (m_v) begin
            check_val("id", 32'(irq_id), m_id);
            check_val("level", 32'(irq_level), m_ol);
            check_val("shv", 32'(irq_shv), 32'(m_os));
        end
    endtask

    task automatic cfg_write(input int idx, input bit ie, input bit ip,
                             input clic_trig_e trig, input int lvl, input bit shv);
        cfg_we = 1'b1;
        cfg_idx = IW'(idx);
        cfg.ie = ie; cfg.ip = ip; cfg.trig = trig; cfg.level = PW'(lvl); cfg.shv = shv;
        step();
        cfg_we = 1'b0;
    endtask

    int pool [8] = '{0, 1, 3, 5, 7, 12, 200, 255};

    initial begin
        rst_ni = 1'b0; irq_src = '0; cfg_we = 1'b0; cfg_idx = '0; cfg = '0;
        thresh = '0; ready = 1'b0;
        step(); step();
        check_val("rst_valid", 32'(irq_valid), 32'd0);
        check_val("rst_id", 32'(irq_id), 32'd0);
        check_val("rst_level", 32'(irq_level), 32'd0);
        check_val("rst_shv", 32'(irq_shv), 32'd0);
        rst_ni = 1'b1;

        // 1: basic level-high offer latency
        cfg_write(5, 1, 0, LEVEL_HIGH, 3, 0);
        irq_src[5] = 1'b1;
        repeat (LAT - 1) step();
        check_val("t1_early", 32'(irq_valid), 32'd0);
        step();
        check_val("t1_valid", 32'(irq_valid), 32'd1);
        check_val("t1_id", 32'(irq_id), 32'd5);
        check_val("t1_level", 32'(irq_level), 32'd3);
        irq_src[5] = 1'b0;
        cfg_write(5, 0, 0, LEVEL_HIGH, 3, 0);
        repeat (LAT + 1) step();

        // 2: tie goes to higher id; strictly higher level preempts a held offer
        cfg_write(7, 1, 0, LEVEL_HIGH, 9, 0);
        cfg_write(200, 1, 0, LEVEL_HIGH, 9, 1);
        irq_src[7] = 1'b1; irq_src[200] = 1'b1;
        repeat (LAT + 1) step();
        check_val("t2_tie_id", 32'(irq_id), 32'd200);
        check_val("t2_tie_shv", 32'(irq_shv), 32'd1);
        cfg_write(7, 1, 0, LEVEL_HIGH, 10, 0);
        step();
        check_val("t2_pre_id", 32'(irq_id), 32'd7);
        check_val("t2_pre_lvl", 32'(irq_level), 32'd10);
        irq_src[7] = 1'b0; irq_src[200] = 1'b0;
        cfg_write(7, 0, 0, LEVEL_HIGH, 0, 0);
        cfg_write(200, 0, 0, LEVEL_HIGH, 0, 0);
        repeat (LAT + 1) step();

        // 3: rising-edge source, ack bubble, new edge on ack cycle re-offers
        cfg_write(12, 1, 0, EDGE_POS, 6, 0);
        ready = 1'b1;
        irq_src[12] = 1'b1; step();
        irq_src[12] = 1'b0; step();
        irq_src[12] = 1'b1; step();
        irq_src[12] = 1'b0;
        repeat (LAT - 2) step();
        check_val("t3_bubble", 32'(irq_valid), 32'd0);
        step();
        check_val("t3_reoffer", 32'(irq_valid), 32'd1);
        check_val("t3_reoffer_id", 32'(irq_id), 32'd12);
        step();
        step();
        check_val("t3_cleared", 32'(irq_valid), 32'd0);
        ready = 1'b0;
        cfg_write(12, 0, 0, LEVEL_HIGH, 0, 0);
        repeat (LAT) step();

        // 4: threshold is strict; all-ones blocks everything
        cfg_write(30, 1, 0, LEVEL_HIGH, 5, 0);
        thresh = 8'd5;
        irq_src[30] = 1'b1;
        repeat (LAT + 2) step();
        check_val("t4_blocked", 32'(irq_valid), 32'd0);
        thresh = 8'd4;
        step(); step();
        check_val("t4_open", 32'(irq_valid), 32'd1);
        check_val("t4_open_id", 32'(irq_id), 32'd30);
        thresh = 8'hFF;
        step();
        check_val("t4_allones", 32'(irq_valid), 32'd0);
        thresh = 8'd0;
        irq_src[30] = 1'b0;
        cfg_write(30, 0, 0, LEVEL_HIGH, 0, 0);
        repeat (LAT) step();

        // 5: held offer dropped when line falls; reset mid-offer
        cfg_write(3, 1, 0, LEVEL_HIGH, 2, 1);
        irq_src[3] = 1'b1;
        repeat (LAT) step();
        check_val("t5_offer_id", 32'(irq_id), 32'd3);
        irq_src[3] = 1'b0;
        repeat (LAT - 1) step();
        check_val("t5_hold", 32'(irq_valid), 32'd1);
        step();
        check_val("t5_drop", 32'(irq_valid), 32'd0);
        irq_src[3] = 1'b1;
        repeat (LAT) step();
        rst_ni = 1'b0;
        step();
        check_val("t5_rst_valid", 32'(irq_valid), 32'd0);
        check_val("t5_rst_id", 32'(irq_id), 32'd0);
        check_val("t5_rst_level", 32'(irq_level), 32'd0);
        check_val("t5_rst_shv", 32'(irq_shv), 32'd0);
        rst_ni = 1'b1;
        irq_src = '0;
        step();

        // 6: switching to edge trigger on a high line creates no pending edge
        cfg_write(40, 0, 0, LEVEL_HIGH, 7, 0);
        irq_src[40] = 1'b1;
        repeat (LAT + 1) step();
        cfg_write(40, 1, 0, EDGE_POS, 7, 0);
        repeat (LAT + 2) step();
        check_val("t6_no_spurious", 32'(irq_valid), 32'd0);
        irq_src[40] = 1'b0;
        cfg_write(40, 0, 0, LEVEL_HIGH, 0, 0);

        // randomized traffic on a small pool of sources
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(3) == 0) irq_src[pool[k]] = ~irq_src[pool[k]];
            end
            cfg_we = ($urandom_range(7) == 0);
            cfg_idx = IW'(pool[$urandom_range(7)]);
            cfg.ie = ($urandom_range(3) != 0);
            cfg.ip = 1'($urandom_range(1));
            cfg.trig = clic_trig_e'(2'($urandom_range(3)));
            cfg.level = PW'($urandom_range(15));
            cfg.shv = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) begin
                thresh = ($urandom_range(3) == 0) ? 8'hFF : PW'($urandom_range(10));
            end
            ready = 1'($urandom_range(1));
            rst_ni = ($urandom_range(999) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
